// File: rtl/ppg_pkg.sv
// Shared definitions for the lasso sequencer: state encoding, error codes,
// default timeouts and a small state-classification helper.
package ppg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DOT_ST = 3'd1,
    DOT_WT = 3'd2,
    GAP_WT = 3'd3,
    LAS_ST = 3'd4,
    LAS_WT = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DOT_TMO = 2'b01;
  localparam logic [1:0] ERR_LAS_TMO = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  localparam int DEF_DOT_TMO   = 1000;
  localparam int DEF_LASSO_TMO = 100000;
  localparam int DEF_GAP       = 1;

  // A run is in progress in every state except the three resting states.
  function automatic logic is_busy(input state_t s);
    return !((s == IDLE) || (s == DONE) || (s == ERR));
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating wait timer: clears to zero, counts while enabled and stops at
// the limit; o_hit flags that the limit has been reached.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_hit
);

  logic [W-1:0] r_count;

  // Count register: clear has priority, counting saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != i_limit)) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_hit   = (r_count == i_limit);

endmodule

// File: rtl/lasso_seq.sv
// Sequencer that starts the dot engine, waits for it, idles GAP cycles,
// starts the lasso engine and waits for it, with timeouts and abort.
module lasso_seq
  import ppg_pkg::*;
#(
  parameter int DOT_TMO   = DEF_DOT_TMO,
  parameter int LASSO_TMO = DEF_LASSO_TMO,
  parameter int GAP       = DEF_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        abort,
  output logic        dot_start,
  input  logic        dot_done,
  output logic        lasso_start,
  input  logic        lasso_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] run_cycles
);

  localparam int TW = $clog2(LASSO_TMO + 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_next_code;
  logic [1:0]  r_err_code;
  logic        r_dot_start;
  logic        r_lasso_start;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_run_cycles;
  logic [3:0]  r_gap_cnt;
  logic        w_go_acc;
  logic        w_wait;
  logic [TW-1:0] w_limit;
  logic [TW-1:0] w_tmr;
  logic        w_hit;
  logic        w_first;

  assign w_go_acc = go && !is_busy(r_state);
  assign w_wait   = (r_state == DOT_WT) || (r_state == LAS_WT);
  assign w_limit  = (r_state == LAS_WT) ? TW'(LASSO_TMO) : TW'(DOT_TMO);
  // The first wait cycle still sees the done level left over from a previous run.
  assign w_first  = (w_tmr == '0);

  seq_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_wait),
    .i_en    (w_wait),
    .i_limit (w_limit),
    .o_count (w_tmr),
    .o_hit   (w_hit)
  );

  // Next-state and error-code selection; done beats timeout, abort beats all.
  always_comb begin
    w_next      = r_state;
    w_next_code = r_err_code;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (go) begin
          w_next      = DOT_ST;
          w_next_code = ERR_NONE;
        end else begin
          w_next = r_state;
        end
      end
      DOT_ST: begin
        if (abort) begin
          w_next      = ERR;
          w_next_code = ERR_ABORT;
        end else begin
          w_next = DOT_WT;
        end
      end
      DOT_WT: begin
        if (abort) begin
          w_next      = ERR;
          w_next_code = ERR_ABORT;
        end else if (dot_done && !w_first) begin
          w_next = GAP_WT;
        end else if (w_hit) begin
          w_next      = ERR;
          w_next_code = ERR_DOT_TMO;
        end else begin
          w_next = DOT_WT;
        end
      end
      GAP_WT: begin
        if (abort) begin
          w_next      = ERR;
          w_next_code = ERR_ABORT;
        end else if (r_gap_cnt == 4'(GAP - 1)) begin
          w_next = LAS_ST;
        end else begin
          w_next = GAP_WT;
        end
      end
      LAS_ST: begin
        if (abort) begin
          w_next      = ERR;
          w_next_code = ERR_ABORT;
        end else begin
          w_next = LAS_WT;
        end
      end
      LAS_WT: begin
        if (abort) begin
          w_next      = ERR;
          w_next_code = ERR_ABORT;
        end else if (lasso_done && !w_first) begin
          w_next = DONE;
        end else if (w_hit) begin
          w_next      = ERR;
          w_next_code = ERR_LAS_TMO;
        end else begin
          w_next = LAS_WT;
        end
      end
      default: begin
        w_next      = IDLE;
        w_next_code = ERR_NONE;
      end
    endcase
  end

  // State register and registered outputs decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_err_code    <= ERR_NONE;
      r_dot_start   <= 1'b0;
      r_lasso_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_err_code    <= w_next_code;
      r_dot_start   <= (w_next == DOT_ST);
      r_lasso_start <= (w_next == LAS_ST);
      r_busy        <= is_busy(w_next);
    end
  end

  // Completion flags: set one cycle after DONE/ERR entry, cleared by a new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_go_acc) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= r_done || (r_state == DONE);
      r_err  <= r_err || (r_state == ERR);
    end
  end

  // Run length: the accepting cycle counts as one, then every busy cycle adds one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cycles <= 32'd0;
    end else if (w_go_acc) begin
      r_run_cycles <= 32'd1;
    end else if (is_busy(r_state) && (r_run_cycles != 32'hFFFF_FFFF)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end else begin
      r_run_cycles <= r_run_cycles;
    end
  end

  // Gap counter: counts cycles spent in GAP_WT, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= 4'd0;
    end else if (r_state == GAP_WT) begin
      r_gap_cnt <= r_gap_cnt + 4'd1;
    end else begin
      r_gap_cnt <= 4'd0;
    end
  end

  assign dot_start   = r_dot_start;
  assign lasso_start = r_lasso_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_lasso_seq.sv
// Directed testbench for lasso_seq with DOT_TMO=8, LASSO_TMO=20, GAP=2.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_lasso_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        dot_done = 1'b0;
  logic        lasso_done = 1'b0;
  logic        dot_start;
  logic        lasso_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] run_cycles;

  int n_asrt = 0;
  int n_fail = 0;
  int n_dot = 0;
  int n_las = 0;
  int base_d;
  int base_l;

  lasso_seq #(.DOT_TMO(8), .LASSO_TMO(20), .GAP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .abort       (abort),
    .dot_start   (dot_start),
    .dot_done    (dot_done),
    .lasso_start (lasso_start),
    .lasso_done  (lasso_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  // Count start pulses on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (dot_start === 1'b1) n_dot <= n_dot + 1;
    if (lasso_start === 1'b1) n_las <= n_las + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_run", run_cycles, 32'd0);
    chk("rst_dstart", 32'(dot_start), 32'd0);
    chk("rst_lstart", 32'(lasso_start), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Nominal run: dot_done at timer 3, lasso_done at timer 5
    base_d = n_dot;
    base_l = n_las;
    go = 1'b1;
    tick();                       // DOT_ST
    chk("nom_dstart", 32'(dot_start), 32'd1);
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_run1", run_cycles, 32'd1);
    go = 1'b0;
    tick();                       // DOT_WT t0
    chk("nom_dstart_off", 32'(dot_start), 32'd0);
    repeat (3) tick();            // t3
    dot_done = 1'b1;
    tick();                       // GAP_WT 1
    dot_done = 1'b0;
    tick();                       // GAP_WT 2
    chk("nom_lstart_early", 32'(lasso_start), 32'd0);
    tick();                       // LAS_ST
    chk("nom_lstart", 32'(lasso_start), 32'd1);
    repeat (6) tick();            // LAS_WT t5
    lasso_done = 1'b1;
    tick();                       // DONE entry
    lasso_done = 1'b0;
    chk("nom_busy_off", 32'(busy), 32'd0);
    chk("nom_done_lag", 32'(done), 32'd0);
    tick();
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_err", 32'(err), 32'd0);
    chk("nom_code", 32'(err_code), 32'd0);
    chk("nom_run", run_cycles, 32'd15);
    chk("nom_ndot", 32'(n_dot - base_d), 32'd1);
    chk("nom_nlas", 32'(n_las - base_l), 32'd1);

    // Stale done levels held from before the start pulses
    dot_done = 1'b1;
    go = 1'b1;
    tick();                       // DOT_ST
    go = 1'b0;
    chk("stale_done_clr", 32'(done), 32'd0);
    chk("stale_run1", run_cycles, 32'd1);
    tick();                       // DOT_WT t0 (ignored)
    tick();                       // DOT_WT t1 (accepted at next edge)
    tick();                       // GAP_WT 1
    dot_done = 1'b0;
    tick();                       // GAP_WT 2
    chk("stale_lstart_early", 32'(lasso_start), 32'd0);
    tick();                       // LAS_ST
    chk("stale_lstart", 32'(lasso_start), 32'd1);
    lasso_done = 1'b1;
    tick();                       // LAS_WT t0 (ignored)
    tick();                       // LAS_WT t1
    chk("stale_las_busy", 32'(busy), 32'd1);
    tick();                       // DONE entry
    chk("stale_busy_off", 32'(busy), 32'd0);
    lasso_done = 1'b0;
    tick();
    chk("stale_done", 32'(done), 32'd1);
    chk("stale_run", run_cycles, 32'd9);

    // Dot timeout, with a go pulse while busy that must be ignored
    base_l = n_las;
    go = 1'b1;
    tick();                       // DOT_ST
    go = 1'b0;
    tick();                       // t0
    tick();                       // t1
    go = 1'b1;
    tick();                       // t2
    go = 1'b0;
    chk("busy_go_dstart", 32'(dot_start), 32'd0);
    chk("busy_go_busy", 32'(busy), 32'd1);
    repeat (6) tick();            // t8
    chk("dtmo_busy_t8", 32'(busy), 32'd1);
    tick();                       // ERR entry
    chk("dtmo_busy_off", 32'(busy), 32'd0);
    tick();
    chk("dtmo_err", 32'(err), 32'd1);
    chk("dtmo_code", 32'(err_code), 32'd1);
    chk("dtmo_done", 32'(done), 32'd0);
    chk("dtmo_run", run_cycles, 32'd11);
    chk("dtmo_nlas", 32'(n_las - base_l), 32'd0);

    // Lasso done arriving exactly at the timeout count wins
    go = 1'b1;
    tick();                       // DOT_ST
    go = 1'b0;
    tick();                       // t0
    dot_done = 1'b1;
    tick();                       // t1
    tick();                       // GAP_WT 1
    dot_done = 1'b0;
    tick();                       // GAP_WT 2
    tick();                       // LAS_ST
    tick();                       // LAS_WT t0
    repeat (20) tick();           // t20
    chk("tie_busy_t20", 32'(busy), 32'd1);
    lasso_done = 1'b1;
    tick();
    lasso_done = 1'b0;
    chk("tie_busy_off", 32'(busy), 32'd0);
    tick();
    chk("tie_done", 32'(done), 32'd1);
    chk("tie_err", 32'(err), 32'd0);
    chk("tie_code", 32'(err_code), 32'd0);

    // Lasso timeout
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    dot_done = 1'b1;
    tick();
    tick();
    dot_done = 1'b0;
    tick();
    tick();
    tick();                       // LAS_WT t0
    repeat (20) tick();           // t20
    chk("ltmo_busy_t20", 32'(busy), 32'd1);
    tick();
    chk("ltmo_busy_off", 32'(busy), 32'd0);
    tick();
    chk("ltmo_err", 32'(err), 32'd1);
    chk("ltmo_done", 32'(done), 32'd0);
    chk("ltmo_code", 32'(err_code), 32'd2);
    chk("ltmo_run", run_cycles, 32'd28);

    // Abort on the last GAP_WT cycle, then a clean restart
    base_l = n_las;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    dot_done = 1'b1;
    tick();
    tick();                       // GAP_WT 1
    dot_done = 1'b0;
    tick();                       // GAP_WT 2
    abort = 1'b1;
    tick();                       // ERR entry instead of LAS_ST
    abort = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_lstart", 32'(lasso_start), 32'd0);
    tick();
    chk("abt_err", 32'(err), 32'd1);
    chk("abt_code", 32'(err_code), 32'd3);
    chk("abt_nlas", 32'(n_las - base_l), 32'd0);
    go = 1'b1;
    tick();                       // DOT_ST
    go = 1'b0;
    chk("rs_err", 32'(err), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_code", 32'(err_code), 32'd0);
    chk("rs_run", run_cycles, 32'd1);
    chk("rs_dstart", 32'(dot_start), 32'd1);

    // Reset in LAS_WT with go in the same cycle
    tick();
    dot_done = 1'b1;
    tick();
    tick();
    dot_done = 1'b0;
    tick();
    tick();                       // LAS_ST
    tick();                       // LAS_WT t0
    tick();                       // LAS_WT t1
    rst = 1'b1;
    go = 1'b1;
    tick();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_code", 32'(err_code), 32'd0);
    chk("mrst_run", run_cycles, 32'd0);
    chk("mrst_dstart", 32'(dot_start), 32'd0);
    chk("mrst_lstart", 32'(lasso_start), 32'd0);
    rst = 1'b0;
    go = 1'b0;
    tick();
    chk("mrst_go_busy", 32'(busy), 32'd0);
    chk("mrst_go_dstart", 32'(dot_start), 32'd0);

    // Abort ignored in IDLE; go wins over abort; abort in DOT_ST
    abort = 1'b1;
    tick();
    chk("idle_abt_busy", 32'(busy), 32'd0);
    chk("idle_abt_err", 32'(err), 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("goabt_busy", 32'(busy), 32'd1);
    chk("goabt_dstart", 32'(dot_start), 32'd1);
    tick();                       // abort still high in DOT_ST
    abort = 1'b0;
    chk("dabt_busy", 32'(busy), 32'd0);
    tick();
    chk("dabt_err", 32'(err), 32'd1);
    chk("dabt_code", 32'(err_code), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
